// File: rtl/kmeans_iter_controller_if.sv
// Handshake and control bundle between the k-means iteration sequencer and
// the regfile/go logic plus the datapath blocks it drives.
interface kmeans_iter_controller_if #(
    parameter int CENT_NUM = 8,
    parameter int ADDR_W   = 9,
    parameter int ITER_W   = 8,
    parameter int REG_W    = 4
);
    // Run request side
    logic              go;
    logic              abort;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ITER_W-1:0] max_iter;
    // Convergence checker result
    logic              cnvrg_valid;
    logic              has_converged;
    // Regfile controls
    logic [REG_W-1:0]  reg_num;
    logic              reg_write;
    logic              go_mux;
    // Point RAM controls (active low)
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_csn;
    logic              ram_oen;
    logic              ram_wen;
    // Datapath enables
    logic              ram_in_en;
    logic [CENT_NUM-1:0] cent_en;
    logic              acc_en;
    logic              acc_clr_n;
    logic              first_iter;
    logic              divider_en;
    logic              cnvrg_en;
    logic              cnvrg_clr_n;
    // Run status
    logic              busy;
    logic              interrupt;
    logic [ITER_W-1:0] iter_count;
    logic [1:0]        status;

    // Sequencer side
    modport master (
        input  go, abort, first_addr, last_addr, max_iter, cnvrg_valid, has_converged,
        output reg_num, reg_write, go_mux, ram_addr, ram_csn, ram_oen, ram_wen,
               ram_in_en, cent_en, acc_en, acc_clr_n, first_iter, divider_en,
               cnvrg_en, cnvrg_clr_n, busy, interrupt, iter_count, status
    );

    // Environment side (regfile/go logic and datapath)
    modport slave (
        output go, abort, first_addr, last_addr, max_iter, cnvrg_valid, has_converged,
        input  reg_num, reg_write, go_mux, ram_addr, ram_csn, ram_oen, ram_wen,
               ram_in_en, cent_en, acc_en, acc_clr_n, first_iter, divider_en,
               cnvrg_en, cnvrg_clr_n, busy, interrupt, iter_count, status
    );
endinterface

// File: rtl/kmeans_iter_controller.sv
// K-means iteration sequencer: loads centroids, streams the point range
// through the classification pipe, drains it, updates the means, waits for
// the convergence verdict and writes the centroids back. All outputs are
// registered; the next-cycle output values are decoded from the next state.
module kmeans_iter_controller #(
    parameter int CENT_NUM      = 8,
    parameter int LOG2_CENT     = 3,
    parameter int ADDR_W        = 9,
    parameter int PIPE_DEPTH    = 3,
    parameter int ITER_W        = 8,
    parameter int REG_W         = 4,
    parameter int CENT_REG_BASE = 2
) (
    input  logic clk,
    input  logic rst_n,
    kmeans_iter_controller_if.master bus
);
    localparam int PIPE_LOG = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int CNT_W    = ((LOG2_CENT > PIPE_LOG) ? LOG2_CENT : PIPE_LOG) + 1;
    localparam int SH_W     = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 1;
    localparam logic [CNT_W-1:0] CENT_LAST = CNT_W'(CENT_NUM - 1);
    localparam logic [CNT_W-1:0] PIPE_LAST = CNT_W'(PIPE_DEPTH - 1);
    localparam logic [1:0] ST_CONV  = 2'b00;
    localparam logic [1:0] ST_LIMIT = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;
    localparam logic [1:0] ST_RANGE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_UPDATE, S_CWAIT, S_WBACK, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ITER_W-1:0]   max_q, max_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [ITER_W-1:0]   iter_inc;
    logic [1:0]          status_q, status_d;
    logic [SH_W-1:0]     sh_q, sh_d;
    logic [SH_W:0]       sh_ext;
    logic [REG_W-1:0]    reg_num_q, reg_num_d;
    logic                reg_write_q, reg_write_d;
    logic                go_mux_q, go_mux_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_csn_q, ram_csn_d;
    logic                ram_oen_q, ram_oen_d;
    logic                ram_in_en_q, ram_in_en_d;
    logic [CENT_NUM-1:0] cent_en_q, cent_en_d;
    logic                acc_en_q, acc_en_d;
    logic                acc_clr_n_q, acc_clr_n_d;
    logic                first_iter_q, first_iter_d;
    logic                divider_en_q, divider_en_d;
    logic                cnvrg_en_q, cnvrg_en_d;
    logic                cnvrg_clr_n_q, cnvrg_clr_n_d;
    logic                busy_q, busy_d;
    logic                interrupt_q, interrupt_d;

    // Saturating iteration increment and the issue-delay line that lines
    // acc_en up with the data leaving the classification pipe
    assign iter_inc = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
    assign sh_ext   = {sh_q, ram_in_en_q};

    // Next state, run bookkeeping and the registered output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        first_d      = first_q;
        last_d       = last_q;
        max_d        = max_q;
        iter_d       = iter_q;
        status_d     = status_q;
        first_iter_d = first_iter_q;
        case (state_q)
            S_IDLE: if (bus.go) begin
                if (bus.first_addr <= bus.last_addr) begin
                    state_d      = S_LOAD;
                    cnt_d        = '0;
                    first_d      = bus.first_addr;
                    last_d       = bus.last_addr;
                    max_d        = bus.max_iter;
                    iter_d       = '0;
                    status_d     = ST_CONV;
                    first_iter_d = 1'b1;
                end else begin
                    state_d  = S_DONE;
                    status_d = ST_RANGE;
                end
            end
            S_LOAD: if (cnt_q == CENT_LAST) begin
                state_d = S_STREAM;
                cnt_d   = '0;
                addr_d  = first_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Compare before incrementing so last_addr = all-ones never wraps
            S_STREAM: if (addr_q == last_q) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
            S_DRAIN: if (cnt_q == PIPE_LAST) begin
                state_d = S_UPDATE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_UPDATE: if (cnt_q == CENT_LAST) begin
                state_d = S_CWAIT;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_CWAIT: if (bus.cnvrg_valid) begin
                iter_d = iter_inc;
                if (bus.has_converged) begin
                    state_d  = S_WBACK;
                    cnt_d    = '0;
                    status_d = ST_CONV;
                end else if (max_q != '0 && iter_inc == max_q) begin
                    state_d  = S_WBACK;
                    cnt_d    = '0;
                    status_d = ST_LIMIT;
                end else begin
                    state_d = S_STREAM;
                    addr_d  = first_q;
                end
            end
            S_WBACK: if (cnt_q == CENT_LAST) begin
                state_d = S_DONE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every other transition, including a pending verdict
        if (bus.abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_DONE;
            status_d = ST_ABORT;
            iter_d   = iter_q;
        end

        reg_num_d     = '0;
        reg_write_d   = 1'b0;
        go_mux_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_csn_d     = 1'b1;
        ram_oen_d     = 1'b1;
        ram_in_en_d   = 1'b0;
        cent_en_d     = '0;
        acc_clr_n_d   = 1'b1;
        divider_en_d  = 1'b0;
        cnvrg_en_d    = 1'b0;
        cnvrg_clr_n_d = 1'b1;
        busy_d        = (state_d != S_IDLE);
        interrupt_d   = (state_d == S_DONE);
        acc_en_d      = sh_ext[PIPE_DEPTH-1];
        sh_d          = sh_ext[SH_W-1:0];
        if (state_d == S_DONE || state_d == S_IDLE) begin
            acc_en_d = 1'b0;
            sh_d     = '0;
        end
        case (state_d)
            S_LOAD: begin
                go_mux_d  = 1'b1;
                reg_num_d = REG_W'(CENT_REG_BASE) + REG_W'(cnt_d);
                cent_en_d = CENT_NUM'(1) << cnt_d;
            end
            S_STREAM: begin
                ram_csn_d    = 1'b0;
                ram_oen_d    = 1'b0;
                ram_in_en_d  = 1'b1;
                ram_addr_d   = addr_d;
                acc_clr_n_d  = (state_q == S_STREAM);
                first_iter_d = 1'b0;
            end
            S_UPDATE: begin
                divider_en_d  = 1'b1;
                cnvrg_en_d    = 1'b1;
                cent_en_d     = CENT_NUM'(1) << cnt_d;
                cnvrg_clr_n_d = (state_q == S_UPDATE);
            end
            S_CWAIT: divider_en_d = 1'b1;
            S_WBACK: begin
                reg_write_d = 1'b1;
                reg_num_d   = REG_W'(CENT_REG_BASE) + REG_W'(cnt_d);
            end
            default: ;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            first_q       <= '0;
            last_q        <= '0;
            max_q         <= '0;
            iter_q        <= '0;
            status_q      <= ST_CONV;
            sh_q          <= '0;
            reg_num_q     <= '0;
            reg_write_q   <= 1'b0;
            go_mux_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_csn_q     <= 1'b1;
            ram_oen_q     <= 1'b1;
            ram_in_en_q   <= 1'b0;
            cent_en_q     <= '0;
            acc_en_q      <= 1'b0;
            acc_clr_n_q   <= 1'b0;
            first_iter_q  <= 1'b1;
            divider_en_q  <= 1'b0;
            cnvrg_en_q    <= 1'b0;
            cnvrg_clr_n_q <= 1'b0;
            busy_q        <= 1'b0;
            interrupt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            first_q       <= first_d;
            last_q        <= last_d;
            max_q         <= max_d;
            iter_q        <= iter_d;
            status_q      <= status_d;
            sh_q          <= sh_d;
            reg_num_q     <= reg_num_d;
            reg_write_q   <= reg_write_d;
            go_mux_q      <= go_mux_d;
            ram_addr_q    <= ram_addr_d;
            ram_csn_q     <= ram_csn_d;
            ram_oen_q     <= ram_oen_d;
            ram_in_en_q   <= ram_in_en_d;
            cent_en_q     <= cent_en_d;
            acc_en_q      <= acc_en_d;
            acc_clr_n_q   <= acc_clr_n_d;
            first_iter_q  <= first_iter_d;
            divider_en_q  <= divider_en_d;
            cnvrg_en_q    <= cnvrg_en_d;
            cnvrg_clr_n_q <= cnvrg_clr_n_d;
            busy_q        <= busy_d;
            interrupt_q   <= interrupt_d;
        end
    end

    assign bus.reg_num     = reg_num_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.go_mux      = go_mux_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_csn     = ram_csn_q;
    assign bus.ram_oen     = ram_oen_q;
    assign bus.ram_wen     = 1'b1;
    assign bus.ram_in_en   = ram_in_en_q;
    assign bus.cent_en     = cent_en_q;
    assign bus.acc_en      = acc_en_q;
    assign bus.acc_clr_n   = acc_clr_n_q;
    assign bus.first_iter  = first_iter_q;
    assign bus.divider_en  = divider_en_q;
    assign bus.cnvrg_en    = cnvrg_en_q;
    assign bus.cnvrg_clr_n = cnvrg_clr_n_q;
    assign bus.busy        = busy_q;
    assign bus.interrupt   = interrupt_q;
    assign bus.iter_count  = iter_q;
    assign bus.status      = status_q;
endmodule

// File: tb/tb_kmeans_iter_controller.sv
// Bench for kmeans_iter_controller: a PIPE_DEPTH=3 instance (ifa) and a
// PIPE_DEPTH=1 instance (ifb) share every input, so each directed run also
// checks the single-stage pipe alignment.
module tb_kmeans_iter_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       go, abort, cnvrg_valid, has_converged;
    logic [8:0] first_addr, last_addr;
    logic [7:0] max_iter;
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct {
        int first;
        int last;
        int max_it;
        int conv_on;     // pass number answered with has_converged=1 (0 = never)
        int exp_status;
        int exp_iter;
        int exp_passes;
        int exp_acc;
    } vec_t;
    vec_t vecs[7];

    kmeans_iter_controller_if #(.CENT_NUM(8), .ADDR_W(9), .ITER_W(8), .REG_W(4)) ifa ();
    kmeans_iter_controller_if #(.CENT_NUM(8), .ADDR_W(9), .ITER_W(8), .REG_W(4)) ifb ();

    assign ifa.go = go;                  assign ifb.go = go;
    assign ifa.abort = abort;            assign ifb.abort = abort;
    assign ifa.first_addr = first_addr;  assign ifb.first_addr = first_addr;
    assign ifa.last_addr = last_addr;    assign ifb.last_addr = last_addr;
    assign ifa.max_iter = max_iter;      assign ifb.max_iter = max_iter;
    assign ifa.cnvrg_valid = cnvrg_valid;       assign ifb.cnvrg_valid = cnvrg_valid;
    assign ifa.has_converged = has_converged;   assign ifb.has_converged = has_converged;

    kmeans_iter_controller #(
        .CENT_NUM(8), .LOG2_CENT(3), .ADDR_W(9), .PIPE_DEPTH(3),
        .ITER_W(8), .REG_W(4), .CENT_REG_BASE(2)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(ifa));

    kmeans_iter_controller #(
        .CENT_NUM(8), .LOG2_CENT(3), .ADDR_W(9), .PIPE_DEPTH(1),
        .ITER_W(8), .REG_W(4), .CENT_REG_BASE(2)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_csn"}, int'(ifa.ram_csn), 1);
        check({tag, "_oen"}, int'(ifa.ram_oen), 1);
        check({tag, "_wen"}, int'(ifa.ram_wen), 1);
        check({tag, "_first_iter"}, int'(ifa.first_iter), 1);
        check({tag, "_acc_clr_n"}, int'(ifa.acc_clr_n), 0);
        check({tag, "_cnvrg_clr_n"}, int'(ifa.cnvrg_clr_n), 0);
        check({tag, "_busy"}, int'(ifa.busy), 0);
        check({tag, "_irq"}, int'(ifa.interrupt), 0);
        check({tag, "_enables"}, int'({ifa.acc_en, ifa.ram_in_en, ifa.divider_en,
                                       ifa.cnvrg_en, ifa.reg_write, ifa.go_mux}), 0);
        check({tag, "_cent_en"}, int'(ifa.cent_en), 0);
        check({tag, "_reg_num"}, int'(ifa.reg_num), 0);
        check({tag, "_iter"}, int'(ifa.iter_count), 0);
        check({tag, "_status"}, int'(ifa.status), 0);
    endtask

    // One full run: drives go, answers the convergence handshake, and
    // scores every cycle against the expected sequence for the record.
    task automatic run_vec(input int idx, input vec_t v);
        int passes = 0, pos = 0, acc_cnt = 0, acc_cnt1 = 0, acc_bad = 0, acc_bad1 = 0;
        int addr_bad = 0, load_cnt = 0, load_bad = 0, wb_cnt = 0, wb_bad = 0;
        int upd_cnt = 0, upd_pos = 0, upd_bad = 0, cw = 0;
        logic prev_ri = 1'b0, h1 = 1'b0, done = 1'b0;
        logic [2:0] h = 3'b000;
        logic [8:0] exp_addr;
        logic [7:0] one;
        first_addr = 9'(v.first);
        last_addr  = 9'(v.last);
        max_iter   = 8'(v.max_it);
        go = 1'b1;
        step;
        // Scramble the range inputs: the run must use its latched copies
        go = 1'b0; first_addr = 9'h1F0; last_addr = 9'h003; max_iter = 8'd1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            cnvrg_valid = 1'b0; has_converged = 1'b0; go = 1'b0;
            if (ifa.go_mux) begin
                one = 8'(1) << load_cnt;
                if (ifa.reg_num != 4'(2 + load_cnt) || ifa.cent_en != one || !ifa.first_iter) load_bad++;
                load_cnt++;
            end
            if (ifa.reg_write) begin
                if (ifa.reg_num != 4'(2 + wb_cnt) || ifa.cent_en != 8'd0) wb_bad++;
                wb_cnt++;
            end
            if (ifa.ram_in_en) begin
                if (!prev_ri) begin passes++; pos = 0; end
                exp_addr = 9'(v.first + pos);
                if (ifa.ram_addr != exp_addr || ifa.ram_csn || ifa.ram_oen || ifa.first_iter ||
                    ifa.acc_clr_n != (pos != 0)) addr_bad++;
                pos++;
                // Stray verdict and go while streaming must both be ignored
                cnvrg_valid = 1'b1; has_converged = 1'b1; go = 1'b1;
            end
            if (ifa.cnvrg_en) begin
                one = 8'(1) << upd_pos;
                if (ifa.cent_en != one || !ifa.divider_en || ifa.cnvrg_clr_n != (upd_pos != 0)) upd_bad++;
                upd_pos++; upd_cnt++;
            end else begin
                upd_pos = 0;
            end
            if (ifa.acc_en != h[2]) acc_bad++;
            if (ifa.acc_en) acc_cnt++;
            h = {h[1:0], ifa.ram_in_en};
            if (ifb.acc_en != h1) acc_bad1++;
            if (ifb.acc_en) acc_cnt1++;
            h1 = ifb.ram_in_en;
            prev_ri = ifa.ram_in_en;
            if (ifa.divider_en && !ifa.cnvrg_en) begin
                cw++;
                if (cw == 2) begin
                    cnvrg_valid = 1'b1;
                    has_converged = (passes == v.conv_on);
                    cw = 0;
                end
            end else begin
                cw = 0;
            end
            if (ifa.interrupt) done = 1'b1;
            else step;
        end
        check("run_done", int'(done), 1);
        check("run_status", int'(ifa.status), v.exp_status);
        check("run_iter", int'(ifa.iter_count), v.exp_iter);
        check("run_passes", passes, v.exp_passes);
        check("run_acc_cycles", acc_cnt, v.exp_acc);
        check("run_acc_align", acc_bad, 0);
        check("run_acc_cycles_p1", acc_cnt1, v.exp_acc);
        check("run_acc_align_p1", acc_bad1, 0);
        check("run_stream_addr", addr_bad, 0);
        check("run_load_cycles", load_cnt, 8);
        check("run_load_seq", load_bad, 0);
        check("run_update_cycles", upd_cnt, 8 * v.exp_passes);
        check("run_update_seq", upd_bad, 0);
        check("run_wback_cycles", wb_cnt, 8);
        check("run_wback_seq", wb_bad, 0);
        step;
        check("run_irq_one_cycle", int'(ifa.interrupt), 0);
        check("run_idle", int'(ifa.busy), 0);
        check("run_status_hold", int'(ifa.status), v.exp_status);
        $display("run %0d: first=%0d last=%0d max=%0d -> status=%0d iter=%0d passes=%0d acc=%0d",
                 idx, v.first, v.last, v.max_it, ifa.status, ifa.iter_count, passes, acc_cnt);
    endtask

    initial begin
        int k;
        logic seen, csn_low;
        vecs[0] = '{0,   9,   0, 2, 0, 2, 2, 20};
        vecs[1] = '{0,   4,   3, 0, 1, 3, 3, 15};
        vecs[2] = '{100, 102, 5, 1, 0, 1, 1, 3};
        vecs[3] = '{510, 511, 0, 3, 0, 3, 3, 6};
        vecs[4] = '{511, 511, 1, 0, 1, 1, 1, 1};
        vecs[5] = '{7,   12,  1, 1, 0, 1, 1, 6};
        vecs[6] = '{0,   3,   0, 1, 0, 1, 1, 4};

        go = 1'b0; abort = 1'b0; cnvrg_valid = 1'b0; has_converged = 1'b0;
        first_addr = '0; last_addr = '0; max_iter = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset("init");
        step; step;
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reversed range: completes immediately without touching the RAM
        first_addr = 9'd5; last_addr = 9'd4; go = 1'b1;
        seen = 1'b0; csn_low = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            step;
            go = 1'b0;
            if (!ifa.ram_csn) csn_low = 1'b1;
            if (ifa.interrupt) seen = 1'b1;
        end
        check("range_irq", int'(seen), 1);
        check("range_status", int'(ifa.status), 3);
        check("range_no_ram", int'(csn_low), 0);
        step; step;
        check("range_idle", int'(ifa.busy), 0);
        $display("run range: first=5 last=4 -> status=%0d", ifa.status);

        // Abort raised during the 4th STREAM cycle
        first_addr = 9'd20; last_addr = 9'd29; max_iter = 8'd0; go = 1'b1;
        step;
        go = 1'b0;
        k = 0;
        for (int i = 0; i < 50 && k < 4; i++) begin
            if (ifa.ram_in_en) k++;
            if (k < 4) step;
        end
        check("abort_reach_stream", k, 4);
        check("abort_addr", int'(ifa.ram_addr), 23);
        abort = 1'b1;
        step;
        abort = 1'b0;
        check("abort_irq", int'(ifa.interrupt), 1);
        check("abort_csn", int'(ifa.ram_csn), 1);
        check("abort_enables", int'({ifa.acc_en, ifa.ram_in_en, ifa.divider_en,
                                     ifa.cnvrg_en, ifa.reg_write, ifa.go_mux}), 0);
        check("abort_cent_en", int'(ifa.cent_en), 0);
        check("abort_status", int'(ifa.status), 2);
        check("abort_iter", int'(ifa.iter_count), 0);
        step;
        check("abort_idle", int'(ifa.busy), 0);
        $display("run abort: first=20 last=29 -> status=%0d", ifa.status);

        // Reset pulsed during UPDATE, then a normal run
        first_addr = 9'd0; last_addr = 9'd3; max_iter = 8'd0; go = 1'b1;
        step;
        go = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (ifa.cnvrg_en) seen = 1'b1;
            else step;
        end
        check("upd_reached", int'(seen), 1);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            if (ifa.interrupt) seen = 1'b1;
        end
        check("midrst_no_irq", int'(seen), 0);
        rst_n = 1'b1;
        step;
        run_vec(6, vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
